pipe_dest_tracker: RTL and testbench
====================================

PIPE_DEST_TRACKER -- requirements
Module: pipe_dest_tracker

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port id_valid, input, 1 bit: ID stage holds a real instruction.
REQ-004 SHALL have port id_rd, input, 5 bits: ID destination register.
REQ-005 SHALL have port id_rf_enable, input, 1 bit: ID instruction writes the register file.
REQ-006 SHALL have port id_load_instr, input, 1 bit: ID instruction is a load.
REQ-007 SHALL have port control_select, input, 1 bit: hazard unit bubble request for ID->EX.
REQ-008 SHALL have port flush, input, 1 bit: squash the instruction entering or sitting in EX.
REQ-009 SHALL have port mem_ready, input, 1 bit: data memory has returned load data this cycle.
REQ-010 SHALL have ports rd_ex, rd_mem, rd_wb, output, 5 bits each: per-stage destination register.
REQ-011 SHALL have ports EX_RF_Enable, MEM_RF_Enable, WB_RF_Enable, output, 1 bit each: per-stage write enable.
REQ-012 SHALL have port EX_load_instr, output, 1 bit: EX holds a valid load.
REQ-013 SHALL have port mem_stall, output, 1 bit: combinational freeze request to PC, IF/ID, ID/EX and EX/MEM.
REQ-014 SHALL have port mem_error, output, 1 bit: sticky load-timeout flag.

Function
REQ-015 SHALL keep three stage records (EX, MEM, WB), each holding {valid, rd, rf_enable, load}; outputs are these registers directly.
REQ-016 SHALL force rf_enable to 0 when a record is captured with rd = 0 or valid = 0.
REQ-017 SHALL run a two-state FSM: IDLE (no load pending) and WAIT (valid load in MEM without data).
REQ-018 SHALL go IDLE->WAIT when a valid load enters MEM and mem_ready is 0 in that cycle.
REQ-019 SHALL go WAIT->IDLE when mem_ready = 1 or wait_cnt = 15.
REQ-020 SHALL keep a 4-bit wait_cnt: cleared in IDLE, incremented each WAIT cycle, saturating at 15 with no wrap.
REQ-021 SHALL drive mem_stall = MEM.valid & MEM.load & ~mem_ready & (wait_cnt != 15), combinationally, with no cycle delay.
REQ-022 SHALL, when mem_stall = 0, advance EX->MEM and MEM->WB, and load EX from ID per REQ-024.
REQ-023 SHALL, when mem_stall = 1, hold EX and MEM and load WB with a bubble (valid = 0, WB_RF_Enable = 0).
REQ-024 SHALL apply EX load priority flush > control_select > normal capture, where flush and control_select each load a bubble.
REQ-025 SHALL clear EX to a bubble in place on flush during mem_stall, while MEM stays held.
REQ-026 SHALL ignore control_select during mem_stall, because EX is frozen.
REQ-027 SHALL, when wait_cnt = 15 with mem_ready still 0, release the stall, retire the load to WB normally and set mem_error.
REQ-028 SHALL keep mem_error set until reset.
REQ-029 SHALL treat mem_ready = 1 with no load in MEM as a no-op.
REQ-030 SHALL handle back-to-back loads independently: wait_cnt restarts at 0 for each load entering MEM.

Reset
REQ-031 SHALL, while rst_n = 0, immediately clear all stage records (valid, rf_enable, load = 0; rd = 0), set the FSM to IDLE and clear wait_cnt and mem_error.
REQ-032 SHALL drive all outputs to 0 during reset, including mem_stall.
REQ-033 SHALL abandon a load in MEM on mid-operation reset with no completion.
REQ-034 SHALL capture on the first rising edge after rst_n deasserts.

Verification
REQ-035 SHALL cover pipeline flow: ADD rd=5 in ID, mem_ready=1 -> rd_ex=5/EX_RF_Enable=1 at cycle 1, rd_mem=5 at cycle 2, rd_wb=5/WB_RF_Enable=1 at cycle 3.
REQ-036 SHALL cover the r0 write: id_rd=0, id_rf_enable=1 -> EX_RF_Enable=0 and stays 0 through WB.
REQ-037 SHALL cover the load wait: load rd=7 enters MEM, mem_ready low 3 cycles then high -> mem_stall=1 for 3 cycles, WB bubbles for 3 cycles, rd_wb=7 the cycle after mem_ready.
REQ-038 SHALL cover the timeout: load in MEM, mem_ready held 0 -> mem_stall high 15 cycles, deasserts at wait_cnt=15, mem_error=1, load reaches WB.
REQ-039 SHALL cover simultaneous events: flush and control_select together during mem_stall -> EX bubble, MEM unchanged; with no stall, flush wins and EX is a bubble.
REQ-040 SHALL cover reset mid-WAIT: rst_n pulsed low at wait_cnt=6 -> all outputs 0 immediately, FSM IDLE, mem_error=0.

Source files
------------

// File: rtl/pipe_dest_tracker.sv
// Destination-register tracker for the EX/MEM/WB stages with load-wait stall.
// Ports: clk, rst_n, id_* capture, control_select, flush, mem_ready in; rd_*, *_RF_Enable, EX_load_instr, mem_stall, mem_error out.
module pipe_dest_tracker (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       id_valid,
    input  logic [4:0] id_rd,
    input  logic       id_rf_enable,
    input  logic       id_load_instr,
    input  logic       control_select,
    input  logic       flush,
    input  logic       mem_ready,
    output logic [4:0] rd_ex,
    output logic [4:0] rd_mem,
    output logic [4:0] rd_wb,
    output logic       EX_RF_Enable,
    output logic       MEM_RF_Enable,
    output logic       WB_RF_Enable,
    output logic       EX_load_instr,
    output logic       mem_stall,
    output logic       mem_error
);

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       rf_en;
        logic       load;
    } stage_t;

    // The load bit has no reader once an instruction reaches WB.
    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       rf_en;
    } wb_t;

    localparam stage_t     BUBBLE    = '0;
    localparam wb_t        WB_BUBBLE = '0;
    localparam logic [0:0] IDLE      = 1'b0;
    localparam logic [0:0] WAIT      = 1'b1;
    localparam logic [3:0] CNT_MAX   = 4'd15;

    stage_t     id_rec;
    stage_t     ex_q;
    stage_t     mem_q;
    wb_t        wb_q;
    logic [0:0] state_q;
    logic [3:0] wait_cnt;
    logic       err_q;
    logic       mem_load;
    logic       timeout;
    logic       stall;

    // r0 writes and invalid slots never carry a write enable.
    always_comb begin
        id_rec = BUBBLE;
        if (id_valid) begin
            id_rec.valid = 1'b1;
            id_rec.rd    = id_rd;
            id_rec.rf_en = id_rf_enable & (id_rd != 5'd0);
            id_rec.load  = id_load_instr;
        end
    end

    assign mem_load = mem_q.valid & mem_q.load;
    assign timeout  = (wait_cnt == CNT_MAX);
    assign stall    = mem_load & ~mem_ready & ~timeout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q  <= BUBBLE;
            mem_q <= BUBBLE;
            wb_q  <= WB_BUBBLE;
        end else if (stall) begin
            // EX and MEM frozen; only a flush may squash EX in place.
            wb_q <= WB_BUBBLE;
            if (flush) begin
                ex_q <= BUBBLE;
            end
        end else begin
            mem_q      <= ex_q;
            wb_q.valid <= mem_q.valid;
            wb_q.rd    <= mem_q.rd;
            wb_q.rf_en <= mem_q.rf_en;
            if (flush) begin
                ex_q <= BUBBLE;
            end else if (control_select) begin
                ex_q <= BUBBLE;
            end else begin
                ex_q <= id_rec;
            end
        end
    end

    // wait_cnt equals the number of cycles the current load has already
    // waited, so the stall lasts at most 15 cycles (counts 0..14).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            wait_cnt <= 4'd0;
            err_q    <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (mem_load & ~mem_ready) begin
                        state_q  <= WAIT;
                        wait_cnt <= 4'd1;
                    end else begin
                        wait_cnt <= 4'd0;
                    end
                end
                WAIT: begin
                    if (mem_ready | timeout) begin
                        state_q  <= IDLE;
                        wait_cnt <= 4'd0;
                        if (!mem_ready) begin
                            err_q <= 1'b1;
                        end
                    end else if (!timeout) begin
                        wait_cnt <= wait_cnt + 4'd1;
                    end
                end
                default: begin
                    state_q  <= IDLE;
                    wait_cnt <= 4'd0;
                end
            endcase
        end
    end

    assign rd_ex         = ex_q.rd;
    assign rd_mem        = mem_q.rd;
    assign rd_wb         = wb_q.rd;
    assign EX_RF_Enable  = ex_q.rf_en;
    assign MEM_RF_Enable = mem_q.rf_en;
    assign WB_RF_Enable  = wb_q.valid & wb_q.rf_en;
    assign EX_load_instr = ex_q.valid & ex_q.load;
    assign mem_stall     = stall;
    assign mem_error     = err_q;

endmodule

// File: tb/tb_pipe_dest_tracker.sv
// Directed bench for pipe_dest_tracker.
// One task per scenario; inline comparisons against hand-computed values.
module tb_pipe_dest_tracker;

    logic       clk;
    logic       rst_n;
    logic       id_valid;
    logic [4:0] id_rd;
    logic       id_rf_enable;
    logic       id_load_instr;
    logic       control_select;
    logic       flush;
    logic       mem_ready;
    logic [4:0] rd_ex;
    logic [4:0] rd_mem;
    logic [4:0] rd_wb;
    logic       EX_RF_Enable;
    logic       MEM_RF_Enable;
    logic       WB_RF_Enable;
    logic       EX_load_instr;
    logic       mem_stall;
    logic       mem_error;

    int errors = 0;
    int checks = 0;

    pipe_dest_tracker dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .id_valid      (id_valid),
        .id_rd         (id_rd),
        .id_rf_enable  (id_rf_enable),
        .id_load_instr (id_load_instr),
        .control_select(control_select),
        .flush         (flush),
        .mem_ready     (mem_ready),
        .rd_ex         (rd_ex),
        .rd_mem        (rd_mem),
        .rd_wb         (rd_wb),
        .EX_RF_Enable  (EX_RF_Enable),
        .MEM_RF_Enable (MEM_RF_Enable),
        .WB_RF_Enable  (WB_RF_Enable),
        .EX_load_instr (EX_load_instr),
        .mem_stall     (mem_stall),
        .mem_error     (mem_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] rd,
                         input logic rf, input logic ld);
        id_valid      = v;
        id_rd         = rd;
        id_rf_enable  = rf;
        id_load_instr = ld;
    endtask

    task automatic idle_in();
        drive(1'b0, 5'd0, 1'b0, 1'b0);
        control_select = 1'b0;
        flush          = 1'b0;
        mem_ready      = 1'b1;
    endtask

    task automatic test_reset();
        idle_in();
        rst_n = 1'b1;
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({rd_ex, rd_mem, rd_wb} !== 15'd0) begin
            errors++;
            $display("FAIL reset_rd got=%0h exp=0", {rd_ex, rd_mem, rd_wb});
        end
        checks++;
        if ({EX_RF_Enable, MEM_RF_Enable, WB_RF_Enable,
             EX_load_instr, mem_stall, mem_error} !== 6'd0) begin
            errors++;
            $display("FAIL reset_flags got=%0b exp=0",
                     {EX_RF_Enable, MEM_RF_Enable, WB_RF_Enable,
                      EX_load_instr, mem_stall, mem_error});
        end
        drive(1'b1, 5'd3, 1'b1, 1'b0);
        step();
        checks++;
        if ({rd_ex, EX_RF_Enable} !== 6'd0) begin
            errors++;
            $display("FAIL reset_hold got=%0h exp=0", {rd_ex, EX_RF_Enable});
        end
        idle_in();
        rst_n = 1'b1;
    endtask

    task automatic test_flow();
        drive(1'b1, 5'd5, 1'b1, 1'b0);
        step();
        idle_in();
        checks++;
        if (rd_ex !== 5'd5 || EX_RF_Enable !== 1'b1) begin
            errors++;
            $display("FAIL flow_ex got=%0d/%0b exp=5/1", rd_ex, EX_RF_Enable);
        end
        checks++;
        if (mem_stall !== 1'b0) begin
            errors++;
            $display("FAIL flow_nostall got=%0b exp=0", mem_stall);
        end
        step();
        checks++;
        if (rd_mem !== 5'd5 || MEM_RF_Enable !== 1'b1) begin
            errors++;
            $display("FAIL flow_mem got=%0d/%0b exp=5/1", rd_mem, MEM_RF_Enable);
        end
        step();
        checks++;
        if (rd_wb !== 5'd5 || WB_RF_Enable !== 1'b1) begin
            errors++;
            $display("FAIL flow_wb got=%0d/%0b exp=5/1", rd_wb, WB_RF_Enable);
        end
    endtask

    task automatic test_r0();
        drive(1'b1, 5'd0, 1'b1, 1'b0);
        step();
        idle_in();
        checks++;
        if (EX_RF_Enable !== 1'b0) begin
            errors++;
            $display("FAIL r0_ex got=%0b exp=0", EX_RF_Enable);
        end
        step();
        checks++;
        if (MEM_RF_Enable !== 1'b0) begin
            errors++;
            $display("FAIL r0_mem got=%0b exp=0", MEM_RF_Enable);
        end
        step();
        checks++;
        if (WB_RF_Enable !== 1'b0 || rd_wb !== 5'd0) begin
            errors++;
            $display("FAIL r0_wb got=%0b/%0d exp=0/0", WB_RF_Enable, rd_wb);
        end
    endtask

    task automatic test_load_wait();
        drive(1'b1, 5'd7, 1'b1, 1'b1);
        step();
        checks++;
        if (EX_load_instr !== 1'b1 || rd_ex !== 5'd7) begin
            errors++;
            $display("FAIL lw_ex got=%0b/%0d exp=1/7", EX_load_instr, rd_ex);
        end
        idle_in();
        mem_ready = 1'b0;
        step();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (mem_stall !== 1'b1 || rd_mem !== 5'd7) begin
                errors++;
                $display("FAIL lw_stall%0d got=%0b/%0d exp=1/7",
                         i, mem_stall, rd_mem);
            end
            step();
            checks++;
            if (WB_RF_Enable !== 1'b0) begin
                errors++;
                $display("FAIL lw_bubble%0d got=%0b exp=0", i, WB_RF_Enable);
            end
        end
        mem_ready = 1'b1;
        #1;
        checks++;
        if (mem_stall !== 1'b0) begin
            errors++;
            $display("FAIL lw_release got=%0b exp=0", mem_stall);
        end
        step();
        checks++;
        if (rd_wb !== 5'd7 || WB_RF_Enable !== 1'b1) begin
            errors++;
            $display("FAIL lw_wb got=%0d/%0b exp=7/1", rd_wb, WB_RF_Enable);
        end
    endtask

    task automatic test_simultaneous();
        drive(1'b1, 5'd13, 1'b1, 1'b1);
        step();
        drive(1'b1, 5'd14, 1'b1, 1'b0);
        mem_ready = 1'b0;
        step();
        drive(1'b0, 5'd0, 1'b0, 1'b0);
        control_select = 1'b1;
        #1;
        checks++;
        if (mem_stall !== 1'b1) begin
            errors++;
            $display("FAIL sim_stall got=%0b exp=1", mem_stall);
        end
        step();
        checks++;
        if (rd_ex !== 5'd14 || EX_RF_Enable !== 1'b1) begin
            errors++;
            $display("FAIL sim_cs_ignored got=%0d/%0b exp=14/1",
                     rd_ex, EX_RF_Enable);
        end
        flush = 1'b1;
        step();
        checks++;
        if (rd_ex !== 5'd0 || EX_RF_Enable !== 1'b0) begin
            errors++;
            $display("FAIL sim_flush_ex got=%0d/%0b exp=0/0",
                     rd_ex, EX_RF_Enable);
        end
        checks++;
        if (rd_mem !== 5'd13 || MEM_RF_Enable !== 1'b1 || mem_stall !== 1'b1) begin
            errors++;
            $display("FAIL sim_mem_hold got=%0d/%0b/%0b exp=13/1/1",
                     rd_mem, MEM_RF_Enable, mem_stall);
        end
        idle_in();
        step();
        checks++;
        if (rd_wb !== 5'd13 || WB_RF_Enable !== 1'b1) begin
            errors++;
            $display("FAIL sim_wb got=%0d/%0b exp=13/1", rd_wb, WB_RF_Enable);
        end
        drive(1'b1, 5'd15, 1'b1, 1'b0);
        flush          = 1'b1;
        control_select = 1'b1;
        step();
        checks++;
        if (rd_ex !== 5'd0 || EX_RF_Enable !== 1'b0) begin
            errors++;
            $display("FAIL sim_flush_wins got=%0d/%0b exp=0/0",
                     rd_ex, EX_RF_Enable);
        end
        drive(1'b1, 5'd16, 1'b1, 1'b0);
        flush = 1'b0;
        step();
        checks++;
        if (EX_RF_Enable !== 1'b0) begin
            errors++;
            $display("FAIL sim_cs_bubble got=%0b exp=0", EX_RF_Enable);
        end
        control_select = 1'b0;
        step();
        checks++;
        if (rd_ex !== 5'd16 || EX_RF_Enable !== 1'b1) begin
            errors++;
            $display("FAIL sim_capture got=%0d/%0b exp=16/1",
                     rd_ex, EX_RF_Enable);
        end
        idle_in();
        step();
        step();
    endtask

    task automatic test_timeout();
        int n;
        drive(1'b1, 5'd9, 1'b1, 1'b1);
        step();
        idle_in();
        mem_ready = 1'b0;
        step();
        n = 0;
        while (mem_stall === 1'b1 && n < 20) begin
            n++;
            step();
            checks++;
            if (WB_RF_Enable !== 1'b0) begin
                errors++;
                $display("FAIL to_bubble%0d got=%0b exp=0", n, WB_RF_Enable);
            end
        end
        checks++;
        if (n !== 15) begin
            errors++;
            $display("FAIL to_stall_len got=%0d exp=15", n);
        end
        checks++;
        if (rd_mem !== 5'd9 || mem_error !== 1'b0) begin
            errors++;
            $display("FAIL to_pre got=%0d/%0b exp=9/0", rd_mem, mem_error);
        end
        step();
        checks++;
        if (rd_wb !== 5'd9 || WB_RF_Enable !== 1'b1 || mem_error !== 1'b1) begin
            errors++;
            $display("FAIL to_retire got=%0d/%0b/%0b exp=9/1/1",
                     rd_wb, WB_RF_Enable, mem_error);
        end
        mem_ready = 1'b1;
        step();
        step();
        checks++;
        if (mem_error !== 1'b1) begin
            errors++;
            $display("FAIL to_sticky got=%0b exp=1", mem_error);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        drive(1'b1, 5'd10, 1'b1, 1'b1);
        step();
        drive(1'b1, 5'd11, 1'b1, 1'b1);
        mem_ready = 1'b0;
        step();
        drive(1'b0, 5'd0, 1'b0, 1'b0);
        #1;
        checks++;
        if (mem_stall !== 1'b1 || rd_mem !== 5'd10) begin
            errors++;
            $display("FAIL b2b_first got=%0b/%0d exp=1/10", mem_stall, rd_mem);
        end
        step();
        step();
        checks++;
        if (rd_ex !== 5'd11 || EX_load_instr !== 1'b1) begin
            errors++;
            $display("FAIL b2b_ex_hold got=%0d/%0b exp=11/1",
                     rd_ex, EX_load_instr);
        end
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
        #1;
        checks++;
        if (rd_wb !== 5'd10 || rd_mem !== 5'd11 || mem_stall !== 1'b1) begin
            errors++;
            $display("FAIL b2b_adv got=%0d/%0d/%0b exp=10/11/1",
                     rd_wb, rd_mem, mem_stall);
        end
        n = 0;
        while (mem_stall === 1'b1 && n < 20) begin
            n++;
            step();
        end
        checks++;
        if (n !== 15) begin
            errors++;
            $display("FAIL b2b_restart got=%0d exp=15", n);
        end
        step();
        checks++;
        if (rd_wb !== 5'd11 || WB_RF_Enable !== 1'b1) begin
            errors++;
            $display("FAIL b2b_wb got=%0d/%0b exp=11/1", rd_wb, WB_RF_Enable);
        end
        idle_in();
        step();
    endtask

    task automatic test_reset_mid_wait();
        drive(1'b1, 5'd17, 1'b1, 1'b1);
        step();
        idle_in();
        mem_ready = 1'b0;
        step();
        repeat (6) step();
        checks++;
        if (mem_stall !== 1'b1 || rd_mem !== 5'd17) begin
            errors++;
            $display("FAIL rmw_pre got=%0b/%0d exp=1/17", mem_stall, rd_mem);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({rd_ex, rd_mem, rd_wb} !== 15'd0) begin
            errors++;
            $display("FAIL rmw_rd got=%0h exp=0", {rd_ex, rd_mem, rd_wb});
        end
        checks++;
        if ({EX_RF_Enable, MEM_RF_Enable, WB_RF_Enable,
             EX_load_instr, mem_stall, mem_error} !== 6'd0) begin
            errors++;
            $display("FAIL rmw_flags got=%0b exp=0",
                     {EX_RF_Enable, MEM_RF_Enable, WB_RF_Enable,
                      EX_load_instr, mem_stall, mem_error});
        end
        step();
        rst_n = 1'b1;
        mem_ready = 1'b1;
        drive(1'b1, 5'd18, 1'b1, 1'b0);
        step();
        idle_in();
        checks++;
        if (rd_ex !== 5'd18 || EX_RF_Enable !== 1'b1 || rd_wb !== 5'd0) begin
            errors++;
            $display("FAIL rmw_capture got=%0d/%0b/%0d exp=18/1/0",
                     rd_ex, EX_RF_Enable, rd_wb);
        end
        step();
        step();
        checks++;
        if (rd_wb !== 5'd18 || mem_error !== 1'b0 || mem_stall !== 1'b0) begin
            errors++;
            $display("FAIL rmw_after got=%0d/%0b/%0b exp=18/0/0",
                     rd_wb, mem_error, mem_stall);
        end
    endtask

    initial begin
        test_reset();
        step();
        test_flow();
        test_r0();
        test_load_wait();
        test_simultaneous();
        test_timeout();
        test_back_to_back();
        test_reset_mid_wait();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
